// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one result bit per clock, LSB first, single full-adder slice.
// Latency: start accepted at edge 0 -> done pulse in the cycle after edge WIDTH+1.
// Backpressure: none; start is taken only in IDLE, ignored in RUN/DONE (busy high).
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   start, sub, a, b  request, op select (0 add / 1 sub) and operands, sampled together
//   busy, done        operation in progress / one-cycle completion pulse
//   sum, c_out, ovf   result mod 2^WIDTH, MSB carry (sub: 1 = no borrow), signed overflow
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_c_out;
  logic             r_c_msb;   // carry into bit WIDTH-1, kept for the overflow flag
  logic             r_busy;
  logic             r_done;

  logic             w_bit;
  logic             w_cout;

  // Full-adder slice on the current operand LSBs.
  assign w_bit  = r_a[0] ^ r_b[0] ^ r_carry;
  assign w_cout = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_c_out <= 1'b0;
      r_c_msb <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      // busy/done are registered views of the state, so they trail it by one
      // cycle: busy spans RUN+DONE as seen outside, done marks the final cycle.
      r_busy <= (r_state != S_IDLE);
      r_done <= (r_state == S_DONE);

      case (r_state)
        S_IDLE: begin
          // While done is still visible the DONE cycle is not over yet, so a
          // start seen in that cycle is dropped.
          if (start && !r_done) begin
            r_a     <= a;
            r_b     <= b ^ {WIDTH{sub}};   // a - b == a + ~b + 1
            r_carry <= sub;
            r_cnt   <= '0;
            r_state <= S_RUN;
          end
        end

        S_RUN: begin
          r_sum   <= {w_bit, r_sum[WIDTH-1:1]};
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_carry <= w_cout;
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == CW'(WIDTH - 1)) begin
            r_c_out <= w_cout;
            r_c_msb <= r_carry;
            r_state <= S_DONE;
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy  = r_busy;
  assign done  = r_done;
  assign sum   = r_sum;
  assign c_out = r_c_out;
  assign ovf   = r_c_msb ^ r_c_out;

endmodule

// File: tb/tb_serial_addsub.sv
module tb_serial_addsub;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       sub;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       c_out;
  logic       ovf;

  int total = 0;
  int bad   = 0;

  serial_addsub #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .c_out (c_out),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (observed timeout, expected completion)");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one operation, scramble inputs after acceptance, wait for done and
  // check latency, result and the end of the pulse.
  task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb_,
                        input logic ts, input logic [7:0] es, input logic ec, input logic eo);
    int n;
    bit seen;
    n    = 0;
    seen = 1'b0;
    @(negedge clk);
    start = 1'b1; a = ta; b = tb_; sub = ts;
    @(posedge clk);
    #1;
    start = 1'b0; a = ~ta; b = ~tb_; sub = ~ts;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        n    = i;
        seen = 1'b1;
        break;
      end
    end
    chk({tag, "_done_seen"}, seen, 1);
    chk({tag, "_latency"}, n, 9);
    chk({tag, "_sum"}, sum, es);
    chk({tag, "_cout"}, c_out, ec);
    chk({tag, "_ovf"}, ovf, eo);
    chk({tag, "_busy_at_done"}, busy, 1);
    @(posedge clk);
    #1;
    chk({tag, "_done_pulse_end"}, done, 0);
    chk({tag, "_busy_end"}, busy, 0);
  endtask

  initial begin
    int busy_cnt;
    int done_cnt;
    logic [7:0] sum_at_done;

    rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = 8'h00; b = 8'h00;
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", c_out, 0);
    chk("rst_ovf", ovf, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("add_35_0a", 8'h35, 8'h0A, 1'b0, 8'h3F, 1'b0, 1'b0);
    run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op("add_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    run_op("sub_05_07", 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0);
    run_op("sub_80_01", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);

    // start re-asserted with different operands during RUN is ignored
    busy_cnt = 0; done_cnt = 0; sum_at_done = 8'h00;
    @(negedge clk);
    start = 1'b1; a = 8'h10; b = 8'h20; sub = 1'b0;
    @(posedge clk);
    #1;
    a = 8'hFF; b = 8'hFF; sub = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      @(posedge clk);
      #1;
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        sum_at_done = sum;
      end
      if (i == 5) start = 1'b0;
    end
    chk("ign_busy_cycles", busy_cnt, 9);
    chk("ign_done_pulses", done_cnt, 1);
    chk("ign_sum", sum_at_done, 8'h30);

    // start in the done cycle is dropped; sum held until a real acceptance
    run_op("b2b_prep", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0);
    // run_op returns one cycle after done; replay with start raised inside done
    @(negedge clk);
    start = 1'b1; a = 8'h01; b = 8'h02; sub = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (done) break;
    end
    chk("b2b_done_high", done, 1);
    start = 1'b1; a = 8'hFF; b = 8'hFF; sub = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("b2b_dropped_busy", busy, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("b2b_still_idle", busy, 0);
    chk("b2b_sum_held", sum, 8'h03);
    run_op("b2b_accept", 8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1, 1'b0);

    // reset in the 4th RUN cycle aborts the operation
    @(negedge clk);
    start = 1'b1; a = 8'h55; b = 8'hAA; sub = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rmid_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("rmid_busy", busy, 0);
    chk("rmid_done", done, 0);
    chk("rmid_sum", sum, 0);
    chk("rmid_cout", c_out, 0);
    chk("rmid_ovf", ovf, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (done) done_cnt++;
    end
    chk("rmid_no_done", done_cnt, 0);
    run_op("after_rst", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_addsub.md
SERIAL_ADDSUB -- requirements
Module: serial_addsub

Interface
REQ-001 Parameter WIDTH, default 8: operand and result width in bits; legal range 2 to 32.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 sub  input  1  operation select: 0 = a+b, 1 = a-b; sampled with start.
REQ-006 a  input  WIDTH  first operand; sampled with start.
REQ-007 b  input  WIDTH  second operand; sampled with start.
REQ-008 busy  output  1  high while an operation is in progress (RUN or DONE).
REQ-009 done  output  1  one-cycle pulse; result outputs valid from this cycle.
REQ-010 sum  output  WIDTH  result, modulo 2^WIDTH.
REQ-011 c_out  output  1  carry out of MSB (for subtract: 1 = no borrow).
REQ-012 ovf  output  1  two's-complement signed overflow flag.

Function
REQ-013 The block SHALL compute one result bit per clock, LSB first, with a one-bit full-adder slice and a registered carry.
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-015 In IDLE with start=1, the block SHALL:
  - latch a
  - latch b XOR {WIDTH{sub}}
  - set carry = sub
  - clear the bit counter
  - enter RUN
REQ-016 In IDLE with start=0, the block SHALL stay in IDLE and hold sum, c_out and ovf.
REQ-017 In RUN, each cycle SHALL:
  - add the operand LSBs and the carry
  - shift the result bit into the sum shift register from the MSB side
  - shift both operand registers right by one
  - update carry
  - increment the counter
REQ-018 After the WIDTH-th RUN cycle the FSM SHALL enter DONE; RUN lasts exactly WIDTH cycles.
REQ-019 In DONE the block SHALL assert done for exactly one cycle and then return to IDLE.
REQ-020 Latency: if start is accepted at rising edge 0, done SHALL be high during the cycle following edge WIDTH+1.
REQ-021 sum, c_out and ovf SHALL be final when done rises and SHALL hold until the next accepted start.
REQ-022 c_out SHALL equal the carry out of bit WIDTH-1.
REQ-023 ovf SHALL equal (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1); the carry into the MSB is captured in a dedicated register on the final RUN cycle.
REQ-024 start SHALL be ignored in RUN and DONE, with no effect on state, operands or result; a start in the DONE cycle is dropped.
REQ-025 busy SHALL be high in RUN and DONE and low in IDLE.
REQ-026 Changes on a, b or sub after acceptance SHALL NOT affect the operation in progress.

Reset
REQ-027 While rst_n=0, all of the following SHALL be forced to 0 asynchronously, and the FSM SHALL be in IDLE:
  - busy, done, sum, c_out, ovf
  - internal operand, carry and counter registers
REQ-028 Reset asserted mid-RUN SHALL abort the operation; no done pulse SHALL follow.
REQ-029 After rst_n deasserts, the first start SHALL be accepted on the first rising edge at which start=1.

Verification (WIDTH=8)
REQ-030 Add: start with a=8'h35, b=8'h0A, sub=0 -> done 9 cycles after acceptance; sum=8'h3F, c_out=0, ovf=0.
REQ-031 Unsigned wrap: a=8'hFF, b=8'h01, sub=0 -> sum=8'h00, c_out=1, ovf=0; a=8'h7F, b=8'h01, sub=0 -> sum=8'h80, c_out=0, ovf=1.
REQ-032 Subtract: a=8'h05, b=8'h07, sub=1 -> sum=8'hFE, c_out=0, ovf=0; a=8'h80, b=8'h01, sub=1 -> sum=8'h7F, c_out=1, ovf=1.
REQ-033 Ignored start: start a=8'h10, b=8'h20; assert start again with a=8'hFF during RUN -> sum=8'h30, a single done pulse, busy high for exactly 9 cycles.
REQ-034 Reset mid-operation: drop rst_n on the 4th RUN cycle -> busy, done, sum, c_out, ovf are 0 immediately; no done pulse follows; the next start a=8'h01, b=8'h01 gives sum=8'h02.
REQ-035 Back-to-back: assert start in the cycle done is high -> that start is ignored; re-assert in IDLE -> accepted, and the previous sum is held until then.
